// File: rtl/gen_rr_arbiter.sv
// Round-robin arbiter: one shared lane, registered one-hot grant held until the owner releases.
// Optional forced revoke after MAX_HOLD grant cycles when built with GEN_ARB_TIMEOUT_EN.
module gen_rr_arbiter #(
    parameter int N        = 3,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_gnt, w_gnt_nxt, w_req_m, w_hot;
    logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt, r_ptr, w_ptr_nxt, w_win;
    logic           r_busy, w_busy_nxt, w_any, w_own, w_expire, w_take, w_hold;
    logic [IDW:0]   w_dist [N];
    logic [IDW:0]   w_best;

    // The current owner is masked so a handoff never re-selects it.
    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            assign w_req_m[i] = req[i] & ~r_gnt[i];
            assign w_dist[i]  = (IDW'(i) >= r_ptr) ? (IDW+1)'(i) - {1'b0, r_ptr}
                                                   : (IDW+1)'(i + N) - {1'b0, r_ptr};
            assign w_hot[i]   = (w_win == IDW'(i));
        end
    endgenerate

    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_best = (IDW+1)'(N);
        for (int i = 0; i < N; i++) begin
            if (w_req_m[i] && (w_dist[i] < w_best)) begin
                w_any  = 1'b1;
                w_win  = IDW'(i);
                w_best = w_dist[i];
            end
        end
    end

    assign w_own = |(req & r_gnt);

`ifdef GEN_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] r_hcnt, w_hcnt_nxt;
    logic          r_timeout;

    // Revoke on the edge that would complete MAX_HOLD grant cycles.
    assign w_expire = w_own && (r_hcnt >= HW'(MAX_HOLD - 1));

    always_comb begin
        w_hcnt_nxt = '0;
        if (w_hold)
            w_hcnt_nxt = (r_hcnt == HW'(MAX_HOLD)) ? r_hcnt : r_hcnt + HW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_hcnt    <= w_hcnt_nxt;
            r_timeout <= w_expire;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign w_take = (r_state == S_IDLE) ? w_any : ((!w_own || w_expire) && w_any);
    assign w_hold = (r_state == S_GRANT) && w_own && !w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_busy   <= w_busy_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_GRANT;
            S_GRANT: if ((!w_own || w_expire) && !w_any) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
        w_busy_nxt   = 1'b0;
        w_ptr_nxt    = r_ptr;
        if (w_take) begin
            w_gnt_nxt    = w_hot;
            w_gnt_id_nxt = w_win;
            w_busy_nxt   = 1'b1;
            w_ptr_nxt    = (w_win == IDW'(N - 1)) ? '0 : w_win + IDW'(1);
        end else if (w_hold) begin
            w_gnt_nxt    = r_gnt;
            w_gnt_id_nxt = r_gnt_id;
            w_busy_nxt   = 1'b1;
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;

endmodule

// File: tb/tb_gen_rr_arbiter.sv
// Bench for gen_rr_arbiter (N=3): vector table plus reset/hold sequences, scoreboard-checked.
module tb_gen_rr_arbiter;
    localparam int N = 3, IDW = 2, MAX_HOLD = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy, timeout;

    typedef struct packed {
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic           busy;
        logic           to;
    } exp_t;

    typedef struct {
        logic [N-1:0] req;
        exp_t         exp;
    } vec_t;

    exp_t sb[$];
    vec_t tv[22];
    int   n_chk = 0;
    int   n_fail = 0;

    gen_rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] g, input logic [1:0] id,
                                input logic b, input logic t);
        vec_t v;
        v.req = r;
        v.exp = '{gnt: g, id: id, busy: b, to: t};
        return v;
    endfunction

    task automatic check(input string nm);
        exp_t e, a;
        n_chk++;
        a = '{gnt: gnt, id: gnt_id, busy: busy, to: timeout};
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry queued", nm);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got gnt=%b id=%0d busy=%b timeout=%b, want gnt=%b id=%0d busy=%b timeout=%b",
                         nm, a.gnt, a.id, a.busy, a.to, e.gnt, e.id, e.busy, e.to);
            end
        end
    endtask

    task automatic drive(input string nm, input logic [2:0] r, input logic [2:0] g,
                         input logic [1:0] id, input logic b, input logic t);
        @(negedge clk);
        req = r;
        sb.push_back('{gnt: g, id: id, busy: b, to: t});
        @(posedge clk);
        #1 check(nm);
    endtask

    // Reset asserted between edges must clear the grant at once; rel_req is granted after release.
    task automatic rst_pulse(input string nm, input logic [2:0] rel_req, input logic [2:0] g,
                             input logic [1:0] id);
        @(negedge clk);
        #2 rst_n = 1'b0;
        req = rel_req;
        #1 sb.push_back('0);
        check({nm, "_async_clear"});
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{gnt: g, id: id, busy: 1'b1, to: 1'b0});
        @(posedge clk);
        #1 check({nm, "_first_grant"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // After reset release owner 0 holds and ptr=1.
        tv[0]  = mk(3'b111, 3'b001, 2'd0, 1'b1, 1'b0);
        tv[1]  = mk(3'b110, 3'b010, 2'd1, 1'b1, 1'b0);
        tv[2]  = mk(3'b101, 3'b100, 2'd2, 1'b1, 1'b0);
        tv[3]  = mk(3'b011, 3'b001, 2'd0, 1'b1, 1'b0);
        tv[4]  = mk(3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
        tv[5]  = mk(3'b100, 3'b100, 2'd2, 1'b1, 1'b0);
        tv[6]  = mk(3'b100, 3'b100, 2'd2, 1'b1, 1'b0);
        tv[7]  = mk(3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
        tv[8]  = mk(3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
        tv[9]  = mk(3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        tv[10] = mk(3'b111, 3'b010, 2'd1, 1'b1, 1'b0);
        tv[11] = mk(3'b111, 3'b010, 2'd1, 1'b1, 1'b0);
        tv[12] = mk(3'b101, 3'b100, 2'd2, 1'b1, 1'b0);
        tv[13] = mk(3'b101, 3'b100, 2'd2, 1'b1, 1'b0);
        tv[14] = mk(3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
        tv[15] = mk(3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
        tv[16] = mk(3'b101, 3'b100, 2'd2, 1'b1, 1'b0);
        tv[17] = mk(3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
        tv[18] = mk(3'b110, 3'b010, 2'd1, 1'b1, 1'b0);
        tv[19] = mk(3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
        tv[20] = mk(3'b011, 3'b001, 2'd0, 1'b1, 1'b0);
        tv[21] = mk(3'b000, 3'b000, 2'd0, 1'b0, 1'b0);

        rst_n = 1'b0;
        req   = 3'b111;
        repeat (2) @(posedge clk);
        #1 sb.push_back('0);
        check("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{gnt: 3'b001, id: 2'd0, busy: 1'b1, to: 1'b0});
        @(posedge clk);
        #1 check("reset_release_grant");

        for (int i = 0; i < 22; i++)
            drive($sformatf("vec%0d", i), tv[i].req, tv[i].exp.gnt, tv[i].exp.id,
                  tv[i].exp.busy, tv[i].exp.to);

        // ptr=1 here: requester 1 wins over 0, then holds.
        drive("hold_grant", 3'b011, 3'b010, 2'd1, 1'b1, 1'b0);
`ifndef GEN_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++)
            drive($sformatf("hold_long%0d", i), 3'b011, 3'b010, 2'd1, 1'b1, 1'b0);
`endif
        drive("hold_release", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);

        drive("pre_rst_grant", 3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        rst_pulse("rst_mid1", 3'b010, 3'b010, 2'd1);
        // ptr left at 2 before reset; only ptr=0 makes requester 1 win here.
        rst_pulse("rst_ptr", 3'b110, 3'b010, 2'd1);

`ifdef GEN_ARB_TIMEOUT_EN
        rst_pulse("to_handoff", 3'b011, 3'b001, 2'd0);
        for (int i = 0; i < 3; i++)
            drive($sformatf("to_hold%0d", i), 3'b011, 3'b001, 2'd0, 1'b1, 1'b0);
        drive("to_revoke_handoff", 3'b011, 3'b010, 2'd1, 1'b1, 1'b1);
        drive("to_pulse_end", 3'b011, 3'b010, 2'd1, 1'b1, 1'b0);
        rst_pulse("to_single", 3'b001, 3'b001, 2'd0);
        for (int i = 0; i < 3; i++)
            drive($sformatf("to_shold%0d", i), 3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
        drive("to_revoke_idle", 3'b001, 3'b000, 2'd0, 1'b0, 1'b1);
        drive("to_regrant", 3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gen_rr_arbiter.md
Name: gen_rr_arbiter

Overview:
- Round-robin arbiter that shares one generated resource lane among N requesters.
- Per-requester request and grant logic is replicated with a genvar loop inside a named generate block.
- Grant is registered and held until the owner releases its request.
- Serves as the sequencing front end for multi-lane generate datapaths in the regression designs.

Parameters:
- N, 3, number of requesters (1..8).
- IDW, 2, width of grant index; must satisfy 2**IDW >= N.
- MAX_HOLD, 4, maximum consecutive grant cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  level request per requester.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  IDW  index of current owner; valid when busy=1.
- busy  output  1  resource granted this cycle.
- timeout  output  1  one-cycle pulse on forced revoke; tied 0 without the optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: gnt=0, gnt_id=0, busy=0, timeout=0.
  - Internal: priority pointer ptr=0, hold counter hcnt=0, state IDLE.
  - Deassertion takes effect at the next clk edge.
- State machine: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ... wrapping mod N.
  - At the edge: gnt = one-hot(winner), gnt_id = winner, busy=1, ptr = (winner+1) mod N, hcnt=0, go to GRANT.
  - Latency: 1 cycle from request to grant.
  - If req == 0, stay in IDLE with outputs 0.
- GRANT:
  - While req[gnt_id]=1: hold gnt and gnt_id, hcnt increments and saturates at MAX_HOLD.
  - Owner drops request, other requests present: zero-gap handoff at the same edge to the next winner, scanning from ptr with the old owner's bit masked.
  - Owner drops request, none pending: gnt=0, busy=0, state IDLE.
- Wrap-around: winner N-1 sets ptr=0.
- Simultaneous events:
  - Requests from non-owners never preempt the owner.
  - Requests arriving in the same cycle are resolved by ptr order only.
- N=1: ptr stays 0; grant follows req with 1-cycle latency.
- Reset mid-grant: gnt drops immediately (async). After release, arbitration restarts with ptr=0.
- gnt is always zero or one-hot; gnt_id matches gnt whenever busy=1.

Optional Feature:
- Macro: GEN_ARB_TIMEOUT_EN.
- Defined:
  - When hcnt reaches MAX_HOLD with req[gnt_id] still 1, the grant is revoked at the next edge and timeout pulses for 1 cycle.
  - If other requests are pending, hand off to the next winner with the old owner masked.
  - Otherwise go to IDLE for exactly one cycle; the old owner may then win again.
- Undefined:
  - The grant is held indefinitely, timeout is constant 0, and hcnt logic is removed.

Test Plan:
- Reset: rst_n=0 while req=3'b111 -> gnt=0, busy=0. Release reset -> next edge gnt=3'b001, gnt_id=0.
- Rotation: req=3'b111 held; each owner drops its req for one cycle at its turn -> grant order 0,1,2,0 with zero idle cycles between grants; ptr wraps 2->0.
- Single requester: req=3'b100 only -> gnt=3'b100 one cycle later. Drop req -> gnt=0 and busy=0 the next edge, back to IDLE.
- No preemption: owner 1 holds req; assert req[0] and req[2] -> gnt stays 3'b010. Drop req[1] -> gnt=3'b100 (ptr=2), then 3'b001 after req[2] drops.
- Async reset mid-grant: pulse rst_n low between clock edges while gnt=3'b010 -> gnt=0 immediately. After release with req=3'b010 -> gnt=3'b010 one edge later.
- With GEN_ARB_TIMEOUT_EN and MAX_HOLD=4: requester 0 holds req, req[1]=1 -> after 4 grant cycles timeout=1 for one cycle and gnt=3'b010. Repeat with only req[0] -> one IDLE cycle, then gnt=3'b001 again.
